id_issue_stage: RTL and testbench

Parametrised decode/issue stage for the ARM pipeline. It decodes one instruction per cycle and reads operands from an internal register file with write-back bypass. It evaluates the condition field against the status register, detects RAW hazards against the EXE and MEM stages, and drives a registered ID/EX pipeline register with stall, bubble and flush control. It sits between the IF/ID register and the EXE stage, with no external pipeline register on its output.

---
 rtl/id_issue_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_id_issue_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_stage.sv
// id_issue_stage: ARM decode/issue stage. It decodes one instruction per cycle
// and reads operands from a register file that bypasses the write-back value.
// It checks the condition field, detects RAW hazards against the EXE and MEM
// stages, and drives the ID/EX pipeline register.
// Build option: define ID_FORWARDING_EN when EXE/MEM forwarding exists
// downstream. With it defined, only load-use stalls remain.
module id_issue_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           instruction,
    output logic                  id_ready,
    input  logic [3:0]            sr,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     result_wb,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  ex_valid,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic [3:0]            ex_cmd,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic                  ex_imm,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_signed_imm_24,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2
);

    localparam int NREG = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_UND = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
        OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
        OP_TST = 4'b1000, OP_CMP = 4'b1010, OP_ORR = 4'b1100,
        OP_MOV = 4'b1101, OP_MVN = 4'b1111
    } op_e;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  b;
        logic                  s;
        logic [3:0]            cmd;
        logic [DATA_W-1:0]     val_rn;
        logic [DATA_W-1:0]     val_rm;
        logic                  imm;
        logic [11:0]           shift_operand;
        logic [23:0]           signed_imm_24;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
    } idex_t;

    mode_e                 mode;
    op_e                   opcode;
    logic                  i_bit, s_bit, is_store, two_src;
    logic [REG_ADDR_W-1:0] src1, rd_idx, rm_idx, src2;
    logic [DATA_W-1:0]     rf_q [NREG];
    logic [DATA_W-1:0]     val_rn, val_rm;
    logic                  n_f, z_f, c_f, v_f, cond_pass;
    logic                  uses_rn, uses_rm, exe_match;
    logic                  dec_ok;
    idex_t                 dec, idex_d, idex_q;

    assign mode     = mode_e'(instruction[27:26]);
    assign opcode   = op_e'(instruction[24:21]);
    assign i_bit    = instruction[25];
    assign s_bit    = instruction[20];
    assign src1     = instruction[16 +: REG_ADDR_W];
    assign rd_idx   = instruction[12 +: REG_ADDR_W];
    assign rm_idx   = instruction[0 +: REG_ADDR_W];
    assign is_store = (mode == MODE_MEM) & ~s_bit;
    assign two_src  = is_store | ((mode == MODE_DP) & ~i_bit);
    assign src2     = is_store ? rd_idx : rm_idx;

    // Register file: reset to index pattern, synchronous write-back port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= DATA_W'(i);
        end else if (wb_en) begin
            rf_q[wb_dest] <= result_wb;
        end
    end

    assign val_rn = (wb_en && wb_dest == src1) ? result_wb : rf_q[src1];
    assign val_rm = (wb_en && wb_dest == src2) ? result_wb : rf_q[src2];

    assign {n_f, z_f, c_f, v_f} = sr;

    // Condition field evaluation against the status flags
    always_comb begin
        cond_pass = 1'b0;
        case (instruction[31:28])
            4'h0:    cond_pass = z_f;
            4'h1:    cond_pass = ~z_f;
            4'h2:    cond_pass = c_f;
            4'h3:    cond_pass = ~c_f;
            4'h4:    cond_pass = n_f;
            4'h5:    cond_pass = ~n_f;
            4'h6:    cond_pass = v_f;
            4'h7:    cond_pass = ~v_f;
            4'h8:    cond_pass = c_f & ~z_f;
            4'h9:    cond_pass = ~c_f | z_f;
            4'hA:    cond_pass = (n_f == v_f);
            4'hB:    cond_pass = (n_f != v_f);
            4'hC:    cond_pass = ~z_f & (n_f == v_f);
            4'hD:    cond_pass = z_f | (n_f != v_f);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Instruction decode; anything undecodable or failing its condition becomes a bubble
    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        case (mode)
            MODE_DP: begin
                dec.wb_en = 1'b1;
                dec.s     = s_bit;
                case (opcode)
                    OP_MOV:  dec.cmd = 4'b0001;
                    OP_MVN:  dec.cmd = 4'b1001;
                    OP_ADD:  dec.cmd = 4'b0010;
                    OP_ADC:  dec.cmd = 4'b0011;
                    OP_SUB:  dec.cmd = 4'b0100;
                    OP_SBC:  dec.cmd = 4'b0101;
                    OP_AND:  dec.cmd = 4'b0110;
                    OP_ORR:  dec.cmd = 4'b0111;
                    OP_EOR:  dec.cmd = 4'b1000;
                    OP_CMP: begin
                        dec.cmd   = 4'b0100;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b1;
                    end
                    OP_TST: begin
                        dec.cmd   = 4'b0110;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b1;
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            MODE_MEM: begin
                dec.cmd      = 4'b0010;
                dec.wb_en    = s_bit;
                dec.mem_r_en = s_bit;
                dec.mem_w_en = ~s_bit;
            end
            MODE_BR:  dec.b = 1'b1;
            MODE_UND: dec_ok = 1'b0;
            default:  dec_ok = 1'b0;
        endcase
        dec.valid         = 1'b1;
        dec.val_rn        = val_rn;
        dec.val_rm        = val_rm;
        dec.imm           = i_bit;
        dec.shift_operand = instruction[11:0];
        dec.signed_imm_24 = instruction[23:0];
        dec.dest          = rd_idx;
        dec.src1          = src1;
        dec.src2          = src2;
        if (!(dec_ok && cond_pass)) dec = '0;
    end

    assign uses_rn = if_valid & (mode != MODE_BR) &
                     ~((mode == MODE_DP) & (opcode == OP_MOV || opcode == OP_MVN));
    assign uses_rm = if_valid & two_src & (mode != MODE_BR);
    assign exe_match = (uses_rn & (exe_dest == src1)) | (uses_rm & (exe_dest == src2));

`ifdef ID_FORWARDING_EN
    logic unused_mem_ports;
    assign unused_mem_ports = ^{mem_wb_en, mem_dest};
    assign hazard = exe_wb_en & exe_mem_r_en & exe_match;
`else
    logic mem_match;
    logic unused_exe_load;
    assign mem_match = (uses_rn & (mem_dest == src1)) | (uses_rm & (mem_dest == src2));
    assign unused_exe_load = exe_mem_r_en;
    assign hazard = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
`endif

    assign id_ready = if_valid & ~hazard & ~ex_stall & ~flush;

    // ID/EX next state: flush beats stall, stall beats hazard/bubble
    always_comb begin
        idex_d = idex_q;
        if (flush)                    idex_d = '0;
        else if (ex_stall)            idex_d = idex_q;
        else if (hazard || !if_valid) idex_d = '0;
        else                          idex_d = dec;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign ex_valid         = idex_q.valid;
    assign ex_wb_en         = idex_q.wb_en;
    assign ex_mem_r_en      = idex_q.mem_r_en;
    assign ex_mem_w_en      = idex_q.mem_w_en;
    assign ex_b             = idex_q.b;
    assign ex_s             = idex_q.s;
    assign ex_cmd           = idex_q.cmd;
    assign ex_val_rn        = idex_q.val_rn;
    assign ex_val_rm        = idex_q.val_rm;
    assign ex_imm           = idex_q.imm;
    assign ex_shift_operand = idex_q.shift_operand;
    assign ex_signed_imm_24 = idex_q.signed_imm_24;
    assign ex_dest          = idex_q.dest;
    assign ex_src1          = idex_q.src1;
    assign ex_src2          = idex_q.src2;

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a reference model.
module tb_id_issue_stage;

`ifdef ID_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] instruction;
    logic        id_ready;
    logic [3:0]  sr;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] result_wb;
    logic        exe_wb_en, exe_mem_r_en;
    logic [3:0]  exe_dest;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;
    logic        ex_stall, flush, hazard;
    logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
    logic [3:0]  ex_cmd;
    logic [31:0] ex_val_rn, ex_val_rm;
    logic        ex_imm;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;
    logic [3:0]  ex_dest, ex_src1, ex_src2;

    always #5 clk = ~clk;

    id_issue_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
        .id_ready(id_ready), .sr(sr), .wb_en(wb_en), .wb_dest(wb_dest),
        .result_wb(result_wb), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .ex_stall(ex_stall), .flush(flush), .hazard(hazard),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_cmd(ex_cmd),
        .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm(ex_imm),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
    );

    typedef struct packed {
        logic        valid, wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic [31:0] rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  dest, s1, s2;
    } ex_t;

    ex_t dut_ex;
    assign dut_ex = {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_cmd,
                     ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand, ex_signed_imm_24,
                     ex_dest, ex_src1, ex_src2};

    // ---------------- reference model ----------------
    ex_t         exp_q;
    logic [31:0] mrf [16];
    // ALU command per data-processing opcode; -1 marks opcodes that do not issue
    int          dp_map [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [3:0] idx);
        return (wb_en && wb_dest == idx) ? result_wb : mrf[idx];
    endfunction

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_hazard();
        int  mode, op;
        bit  st, urn, urm, me, mm;
        logic [3:0] a, b2;
        mode = int'(instruction[27:26]);
        op   = int'(instruction[24:21]);
        st   = (mode == 1) && !instruction[20];
        a    = instruction[19:16];
        b2   = st ? instruction[15:12] : instruction[3:0];
        urn  = if_valid && mode != 2 && !(mode == 0 && (op == 13 || op == 15));
        urm  = if_valid && mode != 2 && (st || (mode == 0 && !instruction[25]));
        me   = (urn && exe_dest == a) || (urm && exe_dest == b2);
        mm   = (urn && mem_dest == a) || (urm && mem_dest == b2);
        if (FWD) return exe_wb_en && exe_mem_r_en && me;
        return (exe_wb_en && me) || (mem_wb_en && mm);
    endfunction

    function automatic ex_t model_decode(input logic [31:0] ins);
        ex_t e;
        bit  ok, st, flag_only;
        int  op;
        e  = '0;
        ok = 1'b1;
        op = int'(ins[24:21]);
        st = (ins[27:26] == 2'b01) && !ins[20];
        case (ins[27:26])
            2'b00: begin
                ok        = dp_map[op] >= 0;
                flag_only = (op == 8) || (op == 10);
                e.cmd     = 4'(dp_map[op]);
                e.wb      = !flag_only;
                e.s       = ins[20] || flag_only;
            end
            2'b01: begin
                e.cmd = 4'd2;
                e.wb  = ins[20];
                e.mr  = ins[20];
                e.mw  = !ins[20];
            end
            2'b10: e.b = 1'b1;
            default: ok = 1'b0;
        endcase
        if (!(ok && cond_ok(ins[31:28], sr))) return '0;
        e.valid = 1'b1;
        e.rn    = mrd(ins[19:16]);
        e.rm    = mrd(st ? ins[15:12] : ins[3:0]);
        e.imm   = ins[25];
        e.sh    = ins[11:0];
        e.simm  = ins[23:0];
        e.dest  = ins[15:12];
        e.s1    = ins[19:16];
        e.s2    = st ? ins[15:12] : ins[3:0];
        return e;
    endfunction

    // Inputs are driven just after a rising edge; check comb outputs, clock, check ID/EX
    task automatic cycle(input string tag);
        bit  hz;
        ex_t nxt;
        #1;
        hz = model_hazard();
        chk({tag, "/hazard"}, 128'(hazard), 128'(hz));
        chk({tag, "/id_ready"}, 128'(id_ready), 128'(if_valid && !hz && !ex_stall && !flush));
        if (flush)                    nxt = '0;
        else if (ex_stall)            nxt = exp_q;
        else if (hz || !if_valid)     nxt = '0;
        else                          nxt = model_decode(instruction);
        @(posedge clk);
        if (wb_en) mrf[wb_dest] = result_wb;
        exp_q = nxt;
        #1;
        chk({tag, "/idex"}, 128'(dut_ex), 128'(exp_q));
    endtask

    task automatic idle();
        if_valid = 0; instruction = 0; sr = 0; wb_en = 0; wb_dest = 0; result_wb = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0; mem_wb_en = 0; mem_dest = 0;
        ex_stall = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #2;
        chk("reset/idex", 128'(dut_ex), 128'(0));
        for (int i = 0; i < 16; i++) mrf[i] = 32'(i);
        exp_q = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] ins;
        logic [3:0]  sr;
        logic        wb_en;
        logic [3:0]  wb_dest;
        logic [31:0] res;
        logic        exe_wb, exe_mr;
        logic [3:0]  exe_dest;
        logic        mem_wb;
        logic [3:0]  mem_dest;
        logic        flush;
        logic        hz, rdy, valid;
        logic [3:0]  cmd;
        logic        wb, b;
        logic [31:0] rn, rm;
    } vec_t;

    vec_t vt [$];

    initial begin
        rst = 1'b0;
        idle();
        //             ins           sr wb wd res           ew er ed mw md fl hz    rdy   valid cmd         wb    b  rn               rm
        vt.push_back('{32'hE0821003, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    1,    2,          1,    0, 2,               3});
        vt.push_back('{32'hE0821003, 0, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0,    1,    1,    2,          1,    0, 32'hDEADBEEF,    3});
        vt.push_back('{32'hE0821003, 0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0,    1,    1,    2,          1,    0, 2,               32'h12345678});
        vt.push_back('{32'hE0821003, 0, 0, 0, 0,            1, 1, 2, 0, 0, 0, 1,    0,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'hE0821003, 0, 0, 0, 0,            0, 0, 0, 1, 3, 0, !FWD, FWD,  FWD,  FWD ? 2 : 0, FWD, 0, FWD ? 2 : 0,    FWD ? 3 : 0});
        vt.push_back('{32'hE0821003, 0, 0, 0, 0,            1, 0, 3, 0, 0, 0, !FWD, FWD,  FWD,  FWD ? 2 : 0, FWD, 0, FWD ? 2 : 0,    FWD ? 3 : 0});
        vt.push_back('{32'h00821003, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'h00821003, 4, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    1,    2,          1,    0, 2,               3});
        vt.push_back('{32'hE1A05003, 0, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0,    1,    1,    1,          1,    0, 0,               3});
        vt.push_back('{32'hE1510002, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    1,    4,          0,    0, 1,               2});
        vt.push_back('{32'hEA000010, 0, 0, 0, 0,            1, 1, 0, 1, 0, 0, 0,    1,    1,    0,          0,    1, 0,               0});
        vt.push_back('{32'hE5914008, 0, 0, 0, 0,            1, 1, 8, 0, 0, 0, 0,    1,    1,    2,          1,    0, 1,               8});
        vt.push_back('{32'hE5814000, 0, 0, 0, 0,            1, 1, 4, 0, 0, 0, 1,    0,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'hE5814000, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    1,    2,          0,    0, 1,               4});
        vt.push_back('{32'hEC000000, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'hE0E21003, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,    1,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'hF0821003, 15, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0,    1,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'hE2821003, 0, 0, 0, 0,            1, 1, 3, 0, 0, 0, 0,    1,    1,    2,          1,    0, 2,               3});
        vt.push_back('{32'hE0821003, 0, 0, 0, 0,            1, 1, 2, 0, 0, 1, 1,    0,    0,    0,          0,    0, 0,               0});
        vt.push_back('{32'hE0821003, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1, 0,    0,    0,    0,          0,    0, 0,               0});

        foreach (vt[k]) begin
            do_reset();
            if_valid = 1; instruction = vt[k].ins; sr = vt[k].sr;
            wb_en = vt[k].wb_en; wb_dest = vt[k].wb_dest; result_wb = vt[k].res;
            exe_wb_en = vt[k].exe_wb; exe_mem_r_en = vt[k].exe_mr; exe_dest = vt[k].exe_dest;
            mem_wb_en = vt[k].mem_wb; mem_dest = vt[k].mem_dest; flush = vt[k].flush;
            cycle($sformatf("vec%0d", k));
            // inputs are still applied, so hazard/id_ready reflect this vector
            chk($sformatf("vec%0d/tbl_hazard", k), 128'(hazard), 128'(vt[k].hz));
            chk($sformatf("vec%0d/tbl_ready", k), 128'(id_ready), 128'(vt[k].rdy));
            chk($sformatf("vec%0d/tbl_fields", k),
                128'({ex_valid, ex_cmd, ex_wb_en, ex_b, ex_val_rn, ex_val_rm}),
                128'({vt[k].valid, vt[k].cmd, vt[k].wb, vt[k].b, vt[k].rn, vt[k].rm}));
        end

        // Load-use resolves once the load leaves EXE
        do_reset();
        if_valid = 1; instruction = 32'hE0821003;
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 2;
        cycle("loaduse0");
        chk("loaduse0/valid", 128'(ex_valid), 128'(0));
        exe_wb_en = 0; exe_mem_r_en = 0;
        cycle("loaduse1");
        chk("loaduse1/valid_rn", 128'({ex_valid, ex_val_rn}), 128'({1'b1, 32'd2}));

        // Stall holds for 3 cycles even with a hazard and new instruction present
        do_reset();
        if_valid = 1; instruction = 32'hE0821003;
        cycle("stall_issue");
        instruction = 32'hE1A05003; ex_stall = 1; exe_wb_en = 1; exe_dest = 3;
        for (int c = 0; c < 3; c++) begin
            cycle($sformatf("stall%0d", c));
            chk($sformatf("stall%0d/held", c), 128'({ex_valid, ex_cmd, ex_dest, ex_val_rm}),
                128'({1'b1, 4'd2, 4'd1, 32'd3}));
        end
        flush = 1; ex_stall = 0;
        cycle("flush");
        chk("flush/valid", 128'(ex_valid), 128'(0));

        // Asynchronous reset in the middle of a stall
        flush = 0; exe_wb_en = 0; instruction = 32'hE0821003;
        cycle("preissue");
        ex_stall = 1;
        #2 rst = 1'b0;
        #1 chk("async_rst/idex", 128'(dut_ex), 128'(0));
        for (int i = 0; i < 16; i++) mrf[i] = 32'(i);
        exp_q = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("post_rst_stall");
        ex_stall = 0;
        cycle("post_rst_issue");

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            instruction = $urandom;
            if ($urandom_range(0, 3) != 0) instruction[31:28] = 4'hE;
            instruction[19:16] = 4'($urandom_range(0, 5));
            instruction[15:12] = 4'($urandom_range(0, 5));
            instruction[3:0]   = 4'($urandom_range(0, 5));
            sr           = 4'($urandom);
            if_valid     = ($urandom_range(0, 9) != 0);
            wb_en        = 1'($urandom_range(0, 1));
            wb_dest      = 4'($urandom_range(0, 7));
            result_wb    = $urandom;
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 7));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_dest     = 4'($urandom_range(0, 7));
            ex_stall     = ($urandom_range(0, 6) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
